// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding select for a 5-stage pipeline with HI/LO registers.
// All outputs combinational (zero latency); stall freezes PC and IF/ID and injects an ID/EX bubble.
module hazard_forward_unit #(
  parameter int MULT_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] id_rs,
  input  logic [5:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic [5:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memtoreg,
  input  logic       id_reads_hi,
  input  logic       id_reads_lo,
  input  logic       id_is_muldiv,
  output logic [1:0] Forward1A,
  output logic [1:0] Forward1B,
  output logic [1:0] Forward2A,
  output logic [1:0] Forward2B,
  output logic [2:0] Forward3A,
  output logic [2:0] Forward3B,
  output logic       stall
);

  localparam logic [5:0] REG_HI   = 6'd32;
  localparam logic [5:0] REG_LO   = 6'd33;
  localparam logic [5:0] REG_PROD = 6'd34;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] CNT_INIT = 3'(MULT_LAT - 1);

  typedef struct packed {
    logic       valid;
    logic [5:0] dst;
    logic       regwrite;
    logic       memtoreg;
    logic [5:0] rs;
    logic [5:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       reads_hi;
    logic       reads_lo;
  } slot_t;

  slot_t      e_q, e_d;
  slot_t      m_q, m_d;
  slot_t      w_q, w_d;
  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  // r0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic produces(input slot_t s, input logic [5:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != 6'd0);
  endfunction

  function automatic logic produces_prod(input slot_t s);
    return s.valid && s.regwrite && (s.dst == REG_PROD);
  endfunction

  function automatic logic [1:0] fwd_gpr(input slot_t m, input slot_t w,
                                         input logic [5:0] r, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      if (produces(m, r)) begin
        sel = 2'b10;
      end else if (produces(w, r)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // A full product (dst 34) is newer than a single-half write in the same stage.
  function automatic logic [2:0] fwd_hilo(input slot_t m, input slot_t w,
                                          input logic [5:0] r, input logic rd);
    logic [2:0] sel;
    sel = 3'b000;
    if (rd) begin
      if (produces_prod(m)) begin
        sel = 3'b100;
      end else if (produces(m, r)) begin
        sel = 3'b010;
      end else if (produces_prod(w)) begin
        sel = 3'b011;
      end else if (produces(w, r)) begin
        sel = 3'b001;
      end
    end
    return sel;
  endfunction

  logic e_hit;
  logic m_hit;
  logic load_use;
  logic branch_haz;
  logic hilo_user;
  logic mult_haz;

  always_comb begin
    e_hit = (id_uses_rs && produces(e_q, id_rs)) ||
            (id_uses_rt && produces(e_q, id_rt));
    m_hit = (id_uses_rs && produces(m_q, id_rs)) ||
            (id_uses_rt && produces(m_q, id_rt));

    load_use   = e_hit && e_q.memtoreg;
    branch_haz = id_is_branch && (e_hit || (m_hit && m_q.memtoreg));

    hilo_user = id_reads_hi || id_reads_lo || id_is_muldiv ||
                (id_regwrite && ((id_dst == REG_HI) || (id_dst == REG_LO) ||
                                 (id_dst == REG_PROD)));
    mult_haz  = (state_q == ST_BUSY) && hilo_user;

    stall = load_use || branch_haz || mult_haz;
  end

  always_comb begin
    w_d = m_q;
    m_d = e_q;
    e_d = '0;
    if (!stall) begin
      e_d.valid    = 1'b1;
      e_d.dst      = id_dst;
      e_d.regwrite = id_regwrite;
      e_d.memtoreg = id_memtoreg;
      e_d.rs       = id_rs;
      e_d.rt       = id_rt;
      e_d.uses_rs  = id_uses_rs;
      e_d.uses_rt  = id_uses_rt;
      e_d.reads_hi = id_reads_hi;
      e_d.reads_lo = id_reads_lo;
    end
  end

  // The countdown starts once the product writer sits in EX and covers MULT_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (e_q.valid && (e_q.dst == REG_PROD)) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    Forward1A = fwd_gpr(m_q, w_q, id_rs, id_uses_rs);
    Forward1B = fwd_gpr(m_q, w_q, id_rt, id_uses_rt);
    Forward2A = fwd_gpr(m_q, w_q, e_q.rs, e_q.uses_rs);
    Forward2B = fwd_gpr(m_q, w_q, e_q.rt, e_q.uses_rt);
    Forward3A = fwd_hilo(m_q, w_q, REG_LO, e_q.reads_lo);
    Forward3B = fwd_hilo(m_q, w_q, REG_HI, e_q.reads_hi);
  end

  // The W slot only ever acts as a producer; its source-side fields are carried for symmetry.
  logic w_fields_unused;
  assign w_fields_unused = ^{w_q.memtoreg, w_q.rs, w_q.rt, w_q.uses_rs, w_q.uses_rt,
                             w_q.reads_hi, w_q.reads_lo};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit (MULT_LAT = 4).
// Each table row is one ID-stage cycle with the outputs expected during that cycle.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] id_rs, id_rt, id_dst;
  logic       id_uses_rs, id_uses_rt, id_is_branch;
  logic       id_regwrite, id_memtoreg, id_reads_hi, id_reads_lo, id_is_muldiv;
  logic [1:0] Forward1A, Forward1B, Forward2A, Forward2B;
  logic [2:0] Forward3A, Forward3B;
  logic       stall;

  hazard_forward_unit #(.MULT_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_reads_hi(id_reads_hi), .id_reads_lo(id_reads_lo),
    .id_is_muldiv(id_is_muldiv),
    .Forward1A(Forward1A), .Forward1B(Forward1B),
    .Forward2A(Forward2A), .Forward2B(Forward2B),
    .Forward3A(Forward3A), .Forward3B(Forward3B),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] rs;
    logic [5:0] rt;
    logic       urs, urt, br;
    logic [5:0] dst;
    logic       rw, mtr, rhi, rlo, md;
  } ins_t;

  typedef struct packed {
    logic       st;
    logic [1:0] f1a, f1b, f2a, f2b;
    logic [2:0] f3a, f3b;
  } exp_t;

  typedef struct packed {
    ins_t ins;
    exp_t ex;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic ins_t i_nop();
    return '0;
  endfunction

  function automatic ins_t i_add(input int d, input int s, input int t);
    ins_t i = '0;
    i.rs = 6'(s); i.rt = 6'(t); i.urs = 1'b1; i.urt = 1'b1;
    i.dst = 6'(d); i.rw = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_lw(input int d);
    ins_t i = '0;
    i.urs = 1'b1; i.dst = 6'(d); i.rw = 1'b1; i.mtr = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_beq(input int s, input int t);
    ins_t i = '0;
    i.rs = 6'(s); i.rt = 6'(t); i.urs = 1'b1; i.urt = 1'b1; i.br = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_mult(input int s, input int t);
    ins_t i = '0;
    i.rs = 6'(s); i.rt = 6'(t); i.urs = 1'b1; i.urt = 1'b1;
    i.dst = 6'd34; i.rw = 1'b1; i.md = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_mfhi(input int d);
    ins_t i = '0;
    i.dst = 6'(d); i.rw = 1'b1; i.rhi = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_mflo(input int d);
    ins_t i = '0;
    i.dst = 6'(d); i.rw = 1'b1; i.rlo = 1'b1;
    return i;
  endfunction

  function automatic ins_t i_mto(input int s, input int half);
    ins_t i = '0;
    i.rs = 6'(s); i.urs = 1'b1; i.dst = 6'(half); i.rw = 1'b1;
    return i;
  endfunction

  task automatic v(input ins_t i, input logic st, input logic [1:0] f1a, input logic [1:0] f1b,
                   input logic [1:0] f2a, input logic [1:0] f2b,
                   input logic [2:0] f3a, input logic [2:0] f3b);
    vec_t r;
    r.ins = i;
    r.ex.st = st; r.ex.f1a = f1a; r.ex.f1b = f1b; r.ex.f2a = f2a; r.ex.f2b = f2b;
    r.ex.f3a = f3a; r.ex.f3b = f3b;
    vecs.push_back(r);
  endtask

  task automatic drive(input ins_t i);
    id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_is_branch = i.br; id_dst = i.dst; id_regwrite = i.rw; id_memtoreg = i.mtr;
    id_reads_hi = i.rhi; id_reads_lo = i.rlo; id_is_muldiv = i.md;
  endtask

  task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @%0d: got %b expected %b", nm, idx, act, expv);
  endtask

  task automatic chk_all(input int idx, input exp_t e);
    chk("stall", idx, {2'b00, stall}, {2'b00, e.st});
    chk("Forward1A", idx, {1'b0, Forward1A}, {1'b0, e.f1a});
    chk("Forward1B", idx, {1'b0, Forward1B}, {1'b0, e.f1b});
    chk("Forward2A", idx, {1'b0, Forward2A}, {1'b0, e.f2a});
    chk("Forward2B", idx, {1'b0, Forward2B}, {1'b0, e.f2b});
    chk("Forward3A", idx, Forward3A, e.f3a);
    chk("Forward3B", idx, Forward3B, e.f3b);
  endtask

  function automatic exp_t ex_of(input logic st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  initial begin
    ins_t gate;
    // ALU result forwarded EX/MEM then MEM/WB, no stall
    v(i_add(3, 1, 2),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(4, 3, 5),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(6, 3, 7),  0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // load-use on rt: one stall, then MEM/WB forward in EX
    v(i_lw(5),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(8, 9, 5),  1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(8, 9, 5),  0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // load then branch: two stalls, then Forward1A = MEM/WB
    v(i_lw(7),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(7, 10),    1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(7, 10),    1, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(7, 10),    0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // ALU then branch: one stall, then Forward1A = EX/MEM
    v(i_add(7, 1, 2),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(7, 10),    1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(7, 10),    0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // r0 writers and readers everywhere: nothing forwards, nothing stalls
    v(i_add(0, 0, 0),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_lw(0),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_beq(0, 0),     0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(0, 0, 0),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // mult, mfhi right behind it, then mflo held for the 3 BUSY cycles
    v(i_mult(1, 2),    0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mfhi(11),      0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mflo(12),      1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100);
    v(i_mflo(12),      1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mflo(12),      1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mflo(12),      0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // mtlo then two mflo readers: LO result from EX/MEM, then MEM/WB
    v(i_mto(1, 33),    0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mflo(13),      0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mflo(14),      0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 3'b000);
    // mthi, mult, mfhi: product in M wins over older mthi in W
    v(i_mto(1, 32),    0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mult(1, 2),    0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mfhi(15),      0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100);
    v(i_add(16, 1, 2), 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mto(2, 32),    1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_mto(2, 32),    0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    // same register in M and W: EX/MEM has priority
    v(i_add(9, 1, 1),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(9, 2, 2),  0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_add(21, 9, 9), 0, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
    // uses_rs = 0 gates a matching rs; rt still forwards
    gate = '0; gate.rs = 6'd21; gate.rt = 6'd21; gate.urt = 1'b1;
    v(gate,            0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
    v(i_nop(),         0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);

    // reset state with hazard-free ID inputs
    rst_n = 1'b0;
    drive(i_nop());
    repeat (2) @(posedge clk);
    #1;
    drive(i_add(3, 1, 2));
    @(negedge clk);
    chk_all(-1, ex_of(1'b0));
    drive(i_nop());
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      drive(vecs[k].ins);
      @(negedge clk);
      chk_all(k, vecs[k].ex);
      @(posedge clk);
      #1;
    end

    // reset during BUSY aborts the count
    drive(i_mult(1, 2));
    @(negedge clk); chk("h_mult_issue", 100, {2'b00, stall}, 3'b000);
    @(posedge clk); #1;
    drive(i_nop());
    @(negedge clk); chk("h_idle_e_mult", 101, {2'b00, stall}, 3'b000);
    @(posedge clk); #1;
    drive(i_mult(3, 4));
    @(negedge clk); chk("h_busy_muldiv", 102, {2'b00, stall}, 3'b001);
    @(posedge clk); #1;
    drive(i_mfhi(11));
    @(negedge clk); chk("h_busy_cnt2", 103, {2'b00, stall}, 3'b001);
    #1 rst_n = 1'b0;
    #1 chk("h_async_stall", 104, {2'b00, stall}, 3'b000);
    chk("h_async_f3b", 104, Forward3B, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("h_released_idle", 105, {2'b00, stall}, 3'b000);
    @(posedge clk); #1;
    drive(i_mflo(12));
    @(negedge clk); chk_all(106, ex_of(1'b0));
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
